// File: rtl/cache_ubit_pkg.sv
// Shared types and constants for the 2-way cache access sequencer.
package cache_ubit_pkg;

    localparam int IDX_W_DEF = 8;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEMWAIT,
        ST_FILL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cache_ubit_ram.sv
// Per-set used-bit array: async clear, one write port, one registered read port.
module cache_ubit_ram #(
    parameter int IDX_W = 8,
    parameter int SETS  = 2**IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             wbit_i,
    input  logic             we_i,
    output logic             rbit_o
);

    logic [SETS-1:0] mem_q;
    logic            rbit_q;

    // Read returns the pre-write value; a write is visible on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            rbit_q <= 1'b0;
        end else begin
            rbit_q <= mem_q[idx_i];
            if (we_i) mem_q[idx_i] <= wbit_i;
        end
    end

    assign rbit_o = rbit_q;

endmodule

// File: rtl/cache_ubit_seq.sv
// Cache access sequencer: fetch/data arbitration, hit sampling, memory handshake,
// way-write strobe generation and used-bit replacement tracking.
module cache_ubit_seq
    import cache_ubit_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int SETS  = 2**IDX_W
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             IREQ,
    input  logic             DREQ,
    input  logic             DWR,
    input  logic [IDX_W-1:0] IIDX,
    input  logic [IDX_W-1:0] DIDX,
    input  logic             HIT0_n,
    input  logic             HIT1_n,
    input  logic             EWC_n,
    input  logic             LSHADOW,
    input  logic             FMISS,
    input  logic             MACK,
    output logic             IGNT,
    output logic             DGNT,
    output logic [IDX_W-1:0] IDX,
    output logic             MREQ,
    output logic             WCA_n,
    output logic             WAY,
    output logic             USED_n,
    output logic             IDONE,
    output logic             DDONE
);

    state_e           state_q, state_d;
    logic             ignt_q, ignt_d, dgnt_q, dgnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mreq_q, mreq_d;
    logic             wca_n_q, wca_n_d;
    logic             way_q, way_d;
    logic             idone_q, idone_d, ddone_q, ddone_d;
    logic             last_d_q, last_d_d;   // 1: data was granted last
    logic             wr_q, wr_d;
    logic             hit_q, hit_d;
    logic             hway_q, hway_d;
    logic             cach_q, cach_d;
    logic             pick_d;
    logic             used;
    logic             ram_we, ram_wbit;

    cache_ubit_ram #(.IDX_W(IDX_W), .SETS(SETS)) u_ram (
        .clk_i  (CLK),
        .rst_ni (RESET_n),
        .idx_i  (idx_q),
        .wbit_i (ram_wbit),
        .we_i   (ram_we),
        .rbit_o (used)
    );

    always_comb begin
        state_d  = state_q;
        ignt_d   = ignt_q;
        dgnt_d   = dgnt_q;
        idx_d    = idx_q;
        mreq_d   = mreq_q;
        wca_n_d  = 1'b1;
        way_d    = way_q;
        idone_d  = 1'b0;
        ddone_d  = 1'b0;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        hit_d    = hit_q;
        hway_d   = hway_q;
        cach_d   = cach_q;
        pick_d   = 1'b0;
        ram_we   = 1'b0;
        ram_wbit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IREQ || DREQ) begin
                    pick_d  = DREQ && (!IREQ || !last_d_q);
                    ignt_d  = !pick_d;
                    dgnt_d  = pick_d;
                    idx_d   = pick_d ? DIDX : IIDX;
                    wr_d    = pick_d && DWR;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d  = (!HIT0_n || !HIT1_n) && !FMISS;
                hway_d = !HIT0_n ? WAY0 : WAY1;
                cach_d = !EWC_n && !LSHADOW && !FMISS;
                if (!wr_q && hit_d) begin
                    ram_we   = 1'b1;
                    ram_wbit = hway_d;
                    state_d  = ST_DONE;
                end else begin
                    mreq_d  = 1'b1;
                    state_d = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (MACK) begin
                    mreq_d  = 1'b0;
                    state_d = ST_FILL;
                    // Writes are no-allocate: only a write hit touches the cache.
                    if (cach_q && (!wr_q || hit_q)) begin
                        wca_n_d = 1'b0;
                        way_d   = wr_q ? hway_q : !used;
                    end
                end
            end
            ST_FILL: begin
                ram_we   = !wca_n_q;
                ram_wbit = way_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                idone_d  = ignt_q;
                ddone_d  = dgnt_q;
                last_d_d = dgnt_q;
                ignt_d   = 1'b0;
                dgnt_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= ST_IDLE;
            ignt_q   <= 1'b0;
            dgnt_q   <= 1'b0;
            idx_q    <= '0;
            mreq_q   <= 1'b0;
            wca_n_q  <= 1'b1;
            way_q    <= WAY0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            last_d_q <= 1'b1;
            wr_q     <= 1'b0;
            hit_q    <= 1'b0;
            hway_q   <= WAY0;
            cach_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ignt_q   <= ignt_d;
            dgnt_q   <= dgnt_d;
            idx_q    <= idx_d;
            mreq_q   <= mreq_d;
            wca_n_q  <= wca_n_d;
            way_q    <= way_d;
            idone_q  <= idone_d;
            ddone_q  <= ddone_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            hit_q    <= hit_d;
            hway_q   <= hway_d;
            cach_q   <= cach_d;
        end
    end

    assign IGNT   = ignt_q;
    assign DGNT   = dgnt_q;
    assign IDX    = idx_q;
    assign MREQ   = mreq_q;
    assign WCA_n  = wca_n_q;
    assign WAY    = way_q;
    assign USED_n = !used;
    assign IDONE  = idone_q;
    assign DDONE  = ddone_q;

endmodule

// File: tb/tb_cache_ubit_seq.sv
// Self-checking bench for cache_ubit_seq: directed scenarios plus randomized accesses
// against a set-level model of used bits and round-robin priority.
module tb_cache_ubit_seq;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       IREQ = 0, DREQ = 0, DWR = 0;
    logic [7:0] IIDX = '0, DIDX = '0;
    logic       HIT0_n = 1, HIT1_n = 1, EWC_n = 0, LSHADOW = 0, FMISS = 0, MACK = 0;
    logic       IGNT, DGNT, MREQ, WCA_n, WAY, USED_n, IDONE, DDONE;
    logic [7:0] IDX;

    int n_chk = 0;
    int n_fail = 0;

    bit used_m [256];
    bit prefer_d;   // model: data wins a tie when set

    cache_ubit_seq #(.IDX_W(8), .SETS(256)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .IREQ(IREQ), .DREQ(DREQ), .DWR(DWR),
        .IIDX(IIDX), .DIDX(DIDX), .HIT0_n(HIT0_n), .HIT1_n(HIT1_n), .EWC_n(EWC_n),
        .LSHADOW(LSHADOW), .FMISS(FMISS), .MACK(MACK), .IGNT(IGNT), .DGNT(DGNT),
        .IDX(IDX), .MREQ(MREQ), .WCA_n(WCA_n), .WAY(WAY), .USED_n(USED_n),
        .IDONE(IDONE), .DDONE(DDONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (used_m[i]) used_m[i] = 1'b0;
        prefer_d = 1'b0;
    endtask

    // One full access from the IDLE cycle through the DONE pulse.
    task automatic txn(input bit ri, input bit rd, input bit [7:0] ii, input bit [7:0] di,
                       input bit wr, input bit h0n, input bit h1n, input bit ewcn,
                       input bit lsh, input bit fm, input int dly);
        bit gd, w, hit, hw, cach, wca, vic, way_e;
        bit [7:0] ix;
        IREQ = ri; DREQ = rd; IIDX = ii; DIDX = di; DWR = wr;
        HIT0_n = h0n; HIT1_n = h1n; EWC_n = ewcn; LSHADOW = lsh; FMISS = fm;
        gd   = rd && (!ri || prefer_d);
        ix   = gd ? di : ii;
        w    = gd && wr;
        hit  = (!h0n || !h1n) && !fm;
        hw   = h0n;             // way 0 wins when both hit
        cach = !ewcn && !lsh && !fm;
        @(posedge CLK); #1;
        check("ignt", IGNT, !gd);
        check("dgnt", DGNT, gd);
        check("idx", IDX, ix);
        check("done_pulse_end", {IDONE, DDONE}, 0);
        @(posedge CLK); #1;
        if (!w && hit) begin
            check("mreq_on_hit", MREQ, 0);
            check("wca_on_hit", WCA_n, 1);
            used_m[ix] = hw;
        end else begin
            check("mreq", MREQ, 1);
            vic = !used_m[ix];
            for (int k = 0; k < dly; k++) begin
                @(posedge CLK); #1;
                check("mreq_hold", MREQ, 1);
                check("wca_wait", WCA_n, 1);
            end
            MACK = 1'b1;
            @(posedge CLK); #1;
            MACK = 1'b0;
            check("mreq_fall", MREQ, 0);
            wca = cach && (!w || hit);
            check("wca_n", WCA_n, !wca);
            if (wca) begin
                way_e = w ? hw : vic;
                check("way", WAY, way_e);
                used_m[ix] = way_e;
            end
            @(posedge CLK); #1;
            check("wca_n_one_cycle", WCA_n, 1);
            check("no_early_done", {IDONE, DDONE}, 0);
        end
        @(posedge CLK); #1;
        check("idone", IDONE, !gd);
        check("ddone", DDONE, gd);
        check("gnt_drop", {IGNT, DGNT}, 0);
        check("used_n", USED_n, !used_m[ix]);
        if (gd) DREQ = 1'b0; else IREQ = 1'b0;
        prefer_d = !gd;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_gnt", {IGNT, DGNT}, 0);
        check("rst_mreq", MREQ, 0);
        check("rst_done", {IDONE, DDONE}, 0);
        check("rst_wca", WCA_n, 1);
        check("rst_way", WAY, 0);
        check("rst_idx", IDX, 0);
        check("rst_used_n", USED_n, 1);
        RESET_n = 1'b1;
        @(posedge CLK); #1;

        // fetch hit on way 1
        txn(1, 0, 8'd5, 8'd0, 0, 1, 0, 0, 0, 0, 0);
        // read miss with fill, victim way 1
        txn(0, 1, 8'd0, 8'd9, 0, 1, 1, 0, 0, 0, 2);
        // simultaneous from a fetch-preferred state, then again
        txn(1, 1, 8'd3, 8'd4, 0, 0, 1, 0, 0, 0, 0);
        txn(0, 1, 8'd3, 8'd4, 0, 0, 1, 0, 0, 0, 0);
        txn(1, 1, 8'd6, 8'd7, 0, 1, 0, 0, 0, 0, 0);
        txn(1, 1, 8'd6, 8'd7, 0, 1, 0, 0, 0, 0, 0);
        // write hit, then shadowed, then cache-write disabled
        txn(0, 1, 8'd0, 8'd20, 1, 0, 1, 0, 0, 0, 1);
        txn(0, 1, 8'd0, 8'd21, 1, 0, 1, 0, 1, 0, 0);
        txn(0, 1, 8'd0, 8'd22, 1, 0, 1, 1, 0, 0, 3);
        // write miss (no allocate)
        txn(0, 1, 8'd0, 8'd23, 1, 1, 1, 0, 0, 0, 0);
        // forced miss on a read with way-0 hit
        txn(0, 1, 8'd0, 8'd30, 0, 0, 1, 0, 0, 1, 1);

        // reset in the middle of a memory wait
        IREQ = 0; DREQ = 1; DIDX = 8'd5; DWR = 0; HIT0_n = 1; HIT1_n = 1; FMISS = 0;
        @(posedge CLK); @(posedge CLK); #1;
        check("pre_rst_mreq", MREQ, 1);
        #2;
        RESET_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_mreq", MREQ, 0);
        check("rst_async_gnt", {IGNT, DGNT}, 0);
        check("rst_async_used_n", USED_n, 1);
        DREQ = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_no_done", {IDONE, DDONE}, 0);
        check("rst_no_wca", WCA_n, 1);
        RESET_n = 1'b1;
        // index 5 was used=1 before reset; a miss must now pick victim way 1
        txn(1, 1, 8'd5, 8'd9, 0, 1, 1, 0, 0, 0, 0);
        txn(0, 1, 8'd5, 8'd9, 0, 1, 1, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            bit ri, rd;
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) ri = 1'b1;
            txn(ri, rd, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ubit_seq.md
Name: cache_ubit_seq

Overview:
Sequencer and arbiter for the 2-way CPU cache access path. It shares the cache between instruction-fetch and data requesters, samples tag-compare hits, and runs the memory handshake on a miss or a write-through. It generates the way-write strobe WCA_n and maintains one used bit per set to choose the replacement way. It sits between the CPU request logic and the cache tag/data RAMs, and it drives the memory bus request.

Parameters:
IDX_W, 8, width of the cache set index
SETS, 256, number of sets (2**IDX_W); one used bit per set

Ports:
CLK  in  1  system clock, all state changes on rising edge
RESET_n  in  1  asynchronous active-low reset
IREQ  in  1  instruction fetch request, held until IDONE
DREQ  in  1  data request, held until DDONE
DWR  in  1  data request is a write, valid with DREQ
IIDX  in  IDX_W  fetch set index
DIDX  in  IDX_W  data set index
HIT0_n  in  1  way-0 tag hit, active-low, valid in LOOKUP
HIT1_n  in  1  way-1 tag hit, active-low, valid in LOOKUP
EWC_n  in  1  enable write cache, active-low
LSHADOW  in  1  access is in the shadow area, so the cache write is inhibited
FMISS  in  1  force miss
MACK  in  1  memory acknowledge, single-cycle pulse
IGNT  out  1  fetch owns the cache path (IDLE exit through DONE)
DGNT  out  1  data owns the cache path
IDX  out  IDX_W  index to tag/data RAMs, from the granted requester
MREQ  out  1  memory request
WCA_n  out  1  cache write strobe, active-low, one cycle
WAY  out  1  way addressed by WCA_n
USED_n  out  1  used bit of the current IDX, inverted
IDONE  out  1  fetch complete, one-cycle pulse
DDONE  out  1  data complete, one-cycle pulse

Behaviour:
- Reset (async, RESET_n low):
  - state IDLE.
  - IGNT, DGNT, MREQ, IDONE and DDONE are 0.
  - WCA_n is 1; WAY is 0; IDX is 0.
  - All used bits are 0. The last-grant flag selects fetch as the next winner.
- A reset mid-operation aborts the access. MREQ drops asynchronously, and no WCA_n pulse or DONE pulse is issued.
- States are IDLE, LOOKUP, MEMWAIT, FILL, DONE. All outputs are registered.
- IDLE:
  - If only one request is present, grant it.
  - If both are present, grant the requester not granted last (round-robin).
  - The grant is registered: IGNT or DGNT rises on the next edge, IDX latches, and the state moves to LOOKUP.
- LOOKUP (one cycle): sample the hits. hit = (HIT0_n==0) or (HIT1_n==0). If both are low, treat the access as a way-0 hit. cachable = !EWC_n & !LSHADOW & !FMISS. FMISS forces hit to 0.
  - Read or fetch with a hit: set used[IDX] to the hit way, then go to DONE. The first grant-cycle edge is t0, so DONE is at t0+2 and the DONE pulse appears at t0+3.
  - Read or fetch with a miss: go to MEMWAIT. The victim is the way not equal to used[IDX].
  - Write: always go to MEMWAIT (write-through). Remember the hit and the hit way.
- MEMWAIT: MREQ=1 until MACK is sampled high. MREQ falls on the same edge that leaves MEMWAIT. There is no timeout.
- FILL (one cycle):
  - Read or fetch miss, cachable: WCA_n=0 and WAY=victim; set used[IDX] to victim.
  - Write hit, cachable: WCA_n=0 and WAY=hit way; set used[IDX] to hit way.
  - Write miss (no allocate), or not cachable: WCA_n stays 1 and the used bit is unchanged.
  - FILL always proceeds to DONE.
- DONE: pulse IDONE or DDONE for the granted requester, drop the grant, update the last-grant flag, and return to IDLE. A request still high in IDLE after DONE is a new access. There are no back-to-back grants without one IDLE cycle.
- USED_n = ~used[IDX], a registered read that updates one cycle after IDX changes or the bit is written.
- Request deasserted before DONE: a protocol violation. The sequence completes regardless.

Decomposition:
- Package cache_ubit_pkg holds:
  - state enum (IDLE, LOOKUP, MEMWAIT, FILL, DONE);
  - IDX_W default;
  - constants WAY0=0 and WAY1=1.
- Sub-module cache_ubit_ram holds the SETS×1 used-bit array. It has async clear on RESET_n, one write port (idx, wbit, we) and one registered read port.

Test Plan:
- Fetch hit: IREQ=1, IIDX=5, HIT1_n=0 in LOOKUP -> IGNT at t0+1, IDONE pulse at t0+3, no MREQ, used[5]=1, USED_n=0.
- Read miss with fill: DREQ=1, DWR=0, DIDX=9, used[9]=0, both HIT_n=1, cachable -> MREQ held until MACK; next cycle WCA_n=0 with WAY=1, then DDONE; used[9]=1.
- Simultaneous requests: IREQ=DREQ=1 from reset -> fetch granted first; DREQ granted after IDONE plus one IDLE cycle; repeat -> data granted first.
- Write with hit versus shadow: DWR=1, HIT0_n=0, LSHADOW=0 -> MREQ, then WCA_n=0 with WAY=0. Same with LSHADOW=1 or EWC_n=1 -> MREQ, DDONE, no WCA_n pulse, used bit unchanged.
- FMISS with HIT0_n=0 on a read -> treated as a miss, MREQ, no WCA_n pulse.
- Reset mid-MEMWAIT: assert RESET_n=0 while MREQ=1 -> MREQ=0 immediately, all used bits 0, no DONE; after release, IREQ gets a fresh grant.
